// File: rtl/counter_sched_pkg.sv
// Shared types and constants for the counter_sched round-robin counter scheduler.
package counter_sched_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_READ  = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr (wrapping) wins.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  // Scan N candidates starting at ptr and keep the first valid one.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    grant_idx = '0;
    any_grant = 1'b0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) begin
        cand = cand - N;
      end else begin
        cand = cand;
      end
      if (req[cand] && !any_grant) begin
        any_grant = 1'b1;
        grant_idx = cand[IW-1:0];
      end else begin
        any_grant = any_grant;
      end
    end
  end

  // One-hot grant derived from the winning index.
  always_comb begin
    if (any_grant) begin
      grant = {{(N-1){1'b0}}, 1'b1} << grant_idx;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shared up/down counter served round-robin to NUM_REQ requesters with a single response slot.
// Optional saturating arithmetic and o_rsp_sat output enabled by COUNTER_SCHED_SAT_EN.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int BITS = 8,
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [2*NUM_REQ-1:0]  i_req_op,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [ID_W-1:0]       o_rsp_id,
  output logic [OP_W-1:0]       o_rsp_op,
  output logic [BITS-1:0]       o_rsp_value,
  output logic [BITS-1:0]       o_value
`ifdef COUNTER_SCHED_SAT_EN
  ,
  output logic                  o_rsp_sat
`endif
);

  state_t          state;
  state_t          next_state;
  logic [BITS-1:0] count;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  logic            any_grant;
  logic            slot_free;
  logic            xfer;
  op_t             win_op;
  logic [BITS-1:0] new_count;

  function automatic logic [BITS-1:0] apply_op(input logic [BITS-1:0] cur, input op_t op);
    logic [BITS-1:0] nxt;
    nxt = cur;
    case (op)
      OP_READ:  nxt = cur;
`ifdef COUNTER_SCHED_SAT_EN
      OP_INC:   nxt = (&cur) ? cur : cur + BITS'(1);
      OP_DEC:   nxt = (cur == '0) ? cur : cur - BITS'(1);
`else
      OP_INC:   nxt = cur + BITS'(1);
      OP_DEC:   nxt = cur - BITS'(1);
`endif
      OP_CLEAR: nxt = '0;
      default:  nxt = cur;
    endcase
    return nxt;
  endfunction

`ifdef COUNTER_SCHED_SAT_EN
  function automatic logic clipped(input logic [BITS-1:0] cur, input op_t op);
    logic clip;
    clip = 1'b0;
    case (op)
      OP_INC:  clip = &cur;
      OP_DEC:  clip = (cur == '0);
      default: clip = 1'b0;
    endcase
    return clip;
  endfunction
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (i_req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Nothing is accepted during reset; the response slot frees when empty or draining.
  always_comb begin
    slot_free = ~o_rsp_valid | i_rsp_ready;
    if (i_rst) begin
      o_req_ready = '0;
      xfer        = 1'b0;
    end else begin
      o_req_ready = slot_free ? grant : '0;
      xfer        = any_grant & slot_free;
    end
    win_op    = op_t'(i_req_op[{grant_idx, 1'b0} +: OP_W]);
    new_count = apply_op(count, win_op);
    ptr_next  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  // Response-slot occupancy: BUSY holds until drained without a replacing transfer.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (xfer) next_state = ST_BUSY;
        else      next_state = ST_IDLE;
      end
      ST_BUSY: begin
        if (xfer || !i_rsp_ready) next_state = ST_BUSY;
        else                      next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Counter, round-robin pointer and response payload registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count       <= '0;
      ptr         <= '0;
      o_rsp_id    <= '0;
      o_rsp_op    <= 2'b00;
      o_rsp_value <= '0;
`ifdef COUNTER_SCHED_SAT_EN
      o_rsp_sat   <= 1'b0;
`endif
    end else if (xfer) begin
      count       <= new_count;
      ptr         <= ptr_next;
      o_rsp_id    <= grant_idx;
      o_rsp_op    <= win_op;
      o_rsp_value <= new_count;
`ifdef COUNTER_SCHED_SAT_EN
      o_rsp_sat   <= clipped(count, win_op);
`endif
    end else begin
      count       <= count;
      ptr         <= ptr;
    end
  end

  assign o_rsp_valid = (state == ST_BUSY);
  assign o_value     = count;

endmodule
